// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants, framebuffer geometry and the CGA palette.
// The palette is only consulted when VGA_PALETTE_EN is defined.
package vga_pkg;

   localparam int VGA_H_ACTIVE = 640;
   localparam int VGA_H_FP     = 16;
   localparam int VGA_H_SYNC   = 96;
   localparam int VGA_H_BP     = 48;
   localparam int VGA_V_ACTIVE = 480;
   localparam int VGA_V_FP     = 10;
   localparam int VGA_V_SYNC   = 2;
   localparam int VGA_V_BP     = 33;

   localparam int H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
   localparam int V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

   localparam int FB_WIDTH  = 160;
   localparam int FB_HEIGHT = 60;

   localparam int VGA_X_SHIFT  = 2;
   localparam int VGA_Y_SHIFT  = 3;
   localparam int VGA_PIPE_LAT = 2;

   // Index 6 is the usual CGA brown (green halved) rather than dark yellow.
   localparam logic [11:0] CGA_PALETTE [16] = '{
      12'h000, 12'h00A, 12'h0A0, 12'h0AA,
      12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
      12'h555, 12'h55F, 12'h5F5, 12'h5FF,
      12'hF55, 12'hF5F, 12'hFF5, 12'hFFF
   };

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with synchronous reset to a parameterised value.
module vga_delay_line #(
   parameter int               WIDTH     = 1,
   parameter int               DEPTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] stage_q [DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < DEPTH; i++) stage_q[i] <= RESET_VAL;
      end else begin
         stage_q[0] <= i_d;
         for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
   end

   assign o_q = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing, framebuffer addressing and latency-matched colour output.
// Define VGA_PALETTE_EN to map pixel values through the CGA palette instead of grayscale.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = VGA_H_ACTIVE,
   parameter int H_FP     = VGA_H_FP,
   parameter int H_SYNC   = VGA_H_SYNC,
   parameter int H_BP     = VGA_H_BP,
   parameter int V_ACTIVE = VGA_V_ACTIVE,
   parameter int V_FP     = VGA_V_FP,
   parameter int V_SYNC   = VGA_V_SYNC,
   parameter int V_BP     = VGA_V_BP,
   parameter int X_SHIFT  = VGA_X_SHIFT,
   parameter int Y_SHIFT  = VGA_Y_SHIFT,
   parameter int PIPE_LAT = VGA_PIPE_LAT
) (
   input  logic       i_vga_clk,
   input  logic       i_rst,
   input  logic [3:0] i_value,
   output logic [7:0] o_pxlX,
   output logic [7:0] o_pxlY,
   output logic       o_hsync,
   output logic       o_vsync,
   output logic [3:0] o_red,
   output logic [3:0] o_green,
   output logic [3:0] o_blue,
   output logic       o_vblank,
   output logic       o_vblank_start
);

   localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
   localparam logic [9:0] H_SS   = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] H_SE   = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
   localparam logic [9:0] V_SS   = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] V_SE   = 10'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

   function automatic logic [11:0] map_color(input logic [3:0] v);
`ifdef VGA_PALETTE_EN
      return CGA_PALETTE[v];
`else
      return {v, v, v};
`endif
   endfunction

   logic [9:0]  hcnt_p0, vcnt_p0;
   logic        de_raw_p0, hs_raw_p0, vs_raw_p0;
   logic        de_dly, hs_dly, vs_dly;
   logic [11:0] rgb_p1;

   // Stage p0: raster counters; vcnt steps on the hcnt wrap.
   always_ff @(posedge i_vga_clk) begin
      if (i_rst) begin
         hcnt_p0 <= '0;
         vcnt_p0 <= '0;
      end else if (hcnt_p0 == H_LAST) begin
         hcnt_p0 <= '0;
         vcnt_p0 <= (vcnt_p0 == V_LAST) ? 10'd0 : vcnt_p0 + 10'd1;
      end else begin
         hcnt_p0 <= hcnt_p0 + 10'd1;
      end
   end

   assign de_raw_p0 = (hcnt_p0 < H_ACT) && (vcnt_p0 < V_ACT);
   assign hs_raw_p0 = !((hcnt_p0 >= H_SS) && (hcnt_p0 < H_SE));
   assign vs_raw_p0 = !((vcnt_p0 >= V_SS) && (vcnt_p0 < V_SE));

   assign o_pxlX         = de_raw_p0 ? 8'(hcnt_p0 >> X_SHIFT) : 8'd0;
   assign o_pxlY         = de_raw_p0 ? 8'(vcnt_p0 >> Y_SHIFT) : 8'd0;
   assign o_vblank       = (vcnt_p0 >= V_ACT);
   assign o_vblank_start = (hcnt_p0 == 10'd0) && (vcnt_p0 == V_ACT);

   // Delay stages: hold de/syncs until the framebuffer read returns.
   vga_delay_line #(
      .WIDTH     (3),
      .DEPTH     (PIPE_LAT),
      .RESET_VAL (3'b011)
   ) u_align (
      .i_clk (i_vga_clk),
      .i_rst (i_rst),
      .i_d   ({de_raw_p0, hs_raw_p0, vs_raw_p0}),
      .o_q   ({de_dly, hs_dly, vs_dly})
   );

   // Stage p1: output register shared by colour and syncs.
   always_ff @(posedge i_vga_clk) begin
      if (i_rst) begin
         rgb_p1  <= '0;
         o_hsync <= 1'b1;
         o_vsync <= 1'b1;
      end else begin
         rgb_p1  <= de_dly ? map_color(i_value) : 12'h000;
         o_hsync <= hs_dly;
         o_vsync <= vs_dly;
      end
   end

   assign {o_red, o_green, o_blue} = rgb_p1;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size and a scaled-down instance against an arithmetic raster model.
module tb_vga_timing_gen;

   localparam int SH_A = 64, SH_F = 4, SH_S = 8, SH_B = 4;
   localparam int SV_A = 48, SV_F = 2, SV_S = 2, SV_B = 3;

   typedef struct packed {
      logic        hs;
      logic        vs;
      logic [11:0] rgb;
      logic [7:0]  x;
      logic [7:0]  y;
      logic        vb;
      logic        vst;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #20 clk = ~clk;

   logic [3:0] fb [9600];

   logic [3:0] val_d, val_s, r1_d, r1_s;
   logic [7:0] x_d, y_d, x_s, y_s;
   logic       hs_d, vs_d, hs_s, vs_s, vb_d, vb_s, vst_d, vst_s;
   logic [3:0] red_d, grn_d, blu_d, red_s, grn_s, blu_s;

   int t = 0;
   int passed = 0;
   int total = 0;
   bit rec = 1'b0;
   logic prev_hs_d = 1'b1, prev_vs_s = 1'b1;
   int falls_d[$], vfalls_s[$], vst_q_s[$];

   vga_timing_gen dut_d (
      .i_vga_clk (clk), .i_rst (rst), .i_value (val_d),
      .o_pxlX (x_d), .o_pxlY (y_d), .o_hsync (hs_d), .o_vsync (vs_d),
      .o_red (red_d), .o_green (grn_d), .o_blue (blu_d),
      .o_vblank (vb_d), .o_vblank_start (vst_d)
   );

   vga_timing_gen #(
      .H_ACTIVE (SH_A), .H_FP (SH_F), .H_SYNC (SH_S), .H_BP (SH_B),
      .V_ACTIVE (SV_A), .V_FP (SV_F), .V_SYNC (SV_S), .V_BP (SV_B),
      .X_SHIFT (2), .Y_SHIFT (3), .PIPE_LAT (2)
   ) dut_s (
      .i_vga_clk (clk), .i_rst (rst), .i_value (val_s),
      .o_pxlX (x_s), .o_pxlY (y_s), .o_hsync (hs_s), .o_vsync (vs_s),
      .o_red (red_s), .o_green (grn_s), .o_blue (blu_s),
      .o_vblank (vb_s), .o_vblank_start (vst_s)
   );

   function automatic int fb_idx(input logic [7:0] x, input logic [7:0] y);
      return (int'(y) % 60) * 160 + (int'(x) % 160);
   endfunction

   // Framebuffer stand-in with a two-cycle read latency.
   always @(posedge clk) begin
      r1_d  <= fb[fb_idx(x_d, y_d)];
      val_d <= r1_d;
      r1_s  <= fb[fb_idx(x_s, y_s)];
      val_s <= r1_s;
   end

   // CGA: bit2/1/0 add 0xA to R/G/B, bit3 adds 5 to all; colour 6 has its green halved.
   function automatic logic [11:0] cmap(input logic [3:0] v);
`ifdef VGA_PALETTE_EN
      int r, g, b;
      r = (v[2] ? 10 : 0) + (v[3] ? 5 : 0);
      g = (v[1] ? 10 : 0) + (v[3] ? 5 : 0);
      b = (v[0] ? 10 : 0) + (v[3] ? 5 : 0);
      if (v == 4'd6) g = 5;
      return {4'(r), 4'(g), 4'(b)};
`else
      return {v, v, v};
`endif
   endfunction

   function automatic exp_t model(input int tt, input int ha, input int hf, input int hsw,
                                  input int hb, input int va, input int vf, input int vsw,
                                  input int vbp);
      exp_t e;
      int ht, vt, h, v, hd, vd;
      ht = ha + hf + hsw + hb;
      vt = va + vf + vsw + vbp;
      h = tt % ht;
      v = (tt / ht) % vt;
      e.x   = (h < ha && v < va) ? 8'(h / 4) : 8'd0;
      e.y   = (h < ha && v < va) ? 8'(v / 8) : 8'd0;
      e.vb  = (v >= va);
      e.vst = (h == 0 && v == va);
      if (tt < 3) begin
         e.hs  = 1'b1;
         e.vs  = 1'b1;
         e.rgb = 12'h000;
      end else begin
         hd = (tt - 3) % ht;
         vd = ((tt - 3) / ht) % vt;
         e.hs  = !(hd >= ha + hf && hd < ha + hf + hsw);
         e.vs  = !(vd >= va + vf && vd < va + vf + vsw);
         e.rgb = (hd < ha && vd < va) ? cmap(fb[(vd / 8) * 160 + hd / 4]) : 12'h000;
      end
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      assert (got === want) begin
         passed++;
      end else begin
         $error("FAIL %s t=%0d got %0h want %0h", name, t, got, want);
      end
   endtask

   task automatic tick();
      exp_t e;
      @(posedge clk);
      t = rst ? 0 : t + 1;
      @(negedge clk);
      e = model(t, 640, 16, 96, 48, 480, 10, 2, 33);
      chk("d_hsync", 32'(hs_d), 32'(e.hs));
      chk("d_vsync", 32'(vs_d), 32'(e.vs));
      chk("d_rgb", 32'({red_d, grn_d, blu_d}), 32'(e.rgb));
      chk("d_pxl", 32'({x_d, y_d}), 32'({e.x, e.y}));
      chk("d_vblank", 32'({vb_d, vst_d}), 32'({e.vb, e.vst}));
      e = model(t, SH_A, SH_F, SH_S, SH_B, SV_A, SV_F, SV_S, SV_B);
      chk("s_hsync", 32'(hs_s), 32'(e.hs));
      chk("s_vsync", 32'(vs_s), 32'(e.vs));
      chk("s_rgb", 32'({red_s, grn_s, blu_s}), 32'(e.rgb));
      chk("s_pxl", 32'({x_s, y_s}), 32'({e.x, e.y}));
      chk("s_vblank", 32'({vb_s, vst_s}), 32'({e.vb, e.vst}));
      if (rec) begin
         if (prev_hs_d && !hs_d) falls_d.push_back(t);
         if (prev_vs_s && !vs_s) vfalls_s.push_back(t);
         if (vst_s) vst_q_s.push_back(t);
      end
      prev_hs_d = hs_d;
      prev_vs_s = vs_s;
   endtask

   task automatic clear_rec();
      falls_d.delete();
      vfalls_s.delete();
      vst_q_s.delete();
   endtask

   initial begin
      int n;
      for (int i = 0; i < 9600; i++) fb[i] = 4'($urandom_range(0, 15));
      fb[0] = 4'($urandom_range(1, 15));

      // Reset held for 5 cycles.
      rst = 1'b1;
      repeat (5) tick();
      chk("rst_hsync", 32'(hs_d), 32'd1);
      chk("rst_vsync", 32'(vs_d), 32'd1);
      chk("rst_rgb", 32'({red_d, grn_d, blu_d}), 32'd0);
      chk("rst_pxl", 32'({x_d, y_d}), 32'd0);

      // Free run across two scaled frames.
      rst = 1'b0;
      clear_rec();
      rec = 1'b1;
      repeat (9000) begin
         tick();
         if (t == 3)    chk("d_first_rgb", 32'({red_d, grn_d, blu_d}), 32'(cmap(fb[0])));
         if (t == 637)  chk("d_last_x", 32'({x_d, y_d}), {16'd0, 8'd159, 8'd0});
         if (t == 640)  chk("d_blank_x", 32'({x_d, y_d}), 32'd0);
         if (t == 658)  chk("d_hs_pre", 32'(hs_d), 32'd1);
         if (t == 754)  chk("d_hs_end", 32'(hs_d), 32'd0);
         if (t == 755)  chk("d_hs_post", 32'(hs_d), 32'd1);
         if (t == 3823) chk("s_last_xy", 32'({x_s, y_s}), {16'd0, 8'd15, 8'd5});
         if (t == 3824) chk("s_blank_xy", 32'({x_s, y_s}), 32'd0);
      end
      chk("d_hs_fall0", falls_d.size() > 0 ? falls_d[0] : -1, 32'd659);
      chk("d_hs_fall1", falls_d.size() > 1 ? falls_d[1] : -1, 32'd1459);
      chk("s_vs_fall0", vfalls_s.size() > 0 ? vfalls_s[0] : -1, 32'd4003);
      chk("s_vs_fall1", vfalls_s.size() > 1 ? vfalls_s[1] : -1, 32'd8403);
      chk("s_vst_count", vst_q_s.size(), 32'd2);
      chk("s_vst0", vst_q_s.size() > 0 ? vst_q_s[0] : -1, 32'd3840);
      chk("s_vst1", vst_q_s.size() > 1 ? vst_q_s[1] : -1, 32'd8240);

      // Reset mid-frame at scaled line 30, mid-line.
      rec = 1'b0;
      repeat (11217 - t) tick();
      rst = 1'b1;
      n = $urandom_range(1, 6);
      repeat (n) tick();
      rst = 1'b0;
      clear_rec();
      rec = 1'b1;
      repeat (4500) tick();
      chk("mid_vs_fall", vfalls_s.size() > 0 ? vfalls_s[0] : -1, 32'd4003);
      chk("mid_vst", vst_q_s.size() > 0 ? vst_q_s[0] : -1, 32'd3840);
      chk("mid_hs_fall", falls_d.size() > 0 ? falls_d[0] : -1, 32'd659);

      // Randomly placed resets of random length.
      rec = 1'b0;
      for (int k = 0; k < 3; k++) begin
         n = $urandom_range(100, 3000);
         repeat (n) tick();
         rst = 1'b1;
         n = $urandom_range(1, 6);
         repeat (n) tick();
         rst = 1'b0;
      end
      repeat (500) tick();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
